// File: rtl/des_key_scheduler.sv
// des_key_scheduler: 3DES round-subkey generator streaming 48 PC2 subkeys (EDE/DED) over valid/ready
module des_key_scheduler #(
    parameter bit PARITY_CHK = 1'b1,
    parameter bit IDLE_ZERO  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [0:191] keys,
    input  logic         decrypt,
    input  logic         sk_ready,
    output logic         sk_valid,
    output logic [0:47]  subkey,
    output logic [5:0]   sk_idx,
    output logic         sk_last,
    output logic         busy,
    output logic         done,
    output logic         parity_err
);
    localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0][55:0]  pk_q, pk_d;
    logic              dec_q, dec_d;
    logic [1:0]        stage_q, stage_d;
    logic [3:0]        r_q, r_d;
    logic [5:0]        idx_q, idx_d;
    logic [55:0]       cd_q, cd_d;
    logic              par_q, par_d;
    logic [1:0]        nxt_stage;
    logic              cur_dord;
    logic              nxt_dord;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] cd;
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1[i]];
        return cd;
    endfunction

    function automatic logic [0:47] pc2(input logic [55:0] cd);
        logic [0:47] o;
        for (int j = 0; j < 48; j++) o[j] = cd[56-PC2[j]];
        return o;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
        return n == 2 ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input int n);
        return n == 2 ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // Enc-order stages start at C1/D1; dec-order stages start at PC1 itself, which equals C16/D16.
    function automatic logic [55:0] stage_load(input logic [55:0] cd, input logic dord);
        return dord ? cd : {rotl(cd[55:28], 1), rotl(cd[27:0], 1)};
    endfunction

    function automatic logic [55:0] step(input logic [55:0] cd, input logic dord, input logic [3:0] r);
        int n;
        n = dord ? SHIFT[15-int'(r)] : SHIFT[int'(r)+1];
        return dord ? {rotr(cd[55:28], n), rotr(cd[27:0], n)} : {rotl(cd[55:28], n), rotl(cd[27:0], n)};
    endfunction

    function automatic logic parity_bad(input logic [0:191] kb);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 24; b++) bad |= ~^kb[8*b +: 8];
        return bad;
    endfunction

    // Only the PC1 images of the three keys are kept; parity bits never reach C/D.
    // Next-state logic: load on key_load, advance C/D per handshake, chain stages without a bubble.
    always_comb begin
        state_d   = state_q;
        pk_d      = pk_q;
        dec_d     = dec_q;
        stage_d   = stage_q;
        r_d       = r_q;
        idx_d     = idx_q;
        cd_d      = cd_q;
        par_d     = par_q;
        nxt_stage = stage_q + 2'd1;
        cur_dord  = dec_q ^ (stage_q == 2'd1);
        nxt_dord  = dec_q ^ (nxt_stage == 2'd1);
        if (state_q == IDLE && key_load) begin
            pk_d    = {pc1(keys[128:191]), pc1(keys[64:127]), pc1(keys[0:63])};
            dec_d   = decrypt;
            stage_d = 2'd0;
            r_d     = 4'd0;
            idx_d   = 6'd0;
            cd_d    = stage_load(decrypt ? pc1(keys[128:191]) : pc1(keys[0:63]), decrypt);
            par_d   = PARITY_CHK && parity_bad(keys);
            state_d = EMIT;
        end else if (state_q == EMIT && sk_ready) begin
            if (idx_q == 6'd47) begin
                state_d = DONE;
            end else begin
                idx_d = idx_q + 6'd1;
                if (r_q == 4'd15) begin
                    stage_d = nxt_stage;
                    r_d     = 4'd0;
                    cd_d    = stage_load(pk_q[dec_q ? 2'd2 - nxt_stage : nxt_stage], nxt_dord);
                end else begin
                    r_d  = r_q + 4'd1;
                    cd_d = step(cd_q, cur_dord, r_q);
                end
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // State and key-schedule registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pk_q    <= '0;
            dec_q   <= 1'b0;
            stage_q <= 2'd0;
            r_q     <= 4'd0;
            idx_q   <= 6'd0;
            cd_q    <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pk_q    <= pk_d;
            dec_q   <= dec_d;
            stage_q <= stage_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            cd_q    <= cd_d;
            par_q   <= par_d;
        end
    end

    // Output decode; subkey comes straight from the registered C/D so it is stable while stalled.
    always_comb begin
        sk_valid   = state_q == EMIT;
        subkey     = (IDLE_ZERO && !sk_valid) ? 48'd0 : pc2(cd_q);
        sk_idx     = (IDLE_ZERO && !sk_valid) ? 6'd0 : idx_q;
        sk_last    = sk_valid && idx_q == 6'd47;
        busy       = sk_valid;
        done       = state_q == DONE;
        parity_err = par_q;
    end
endmodule

// File: tb/tb_des_key_scheduler.sv
// tb_des_key_scheduler: randomized self-checking bench against a cumulative-rotation DES key schedule model
module tb_des_key_scheduler;
    logic         clk = 1'b0;
    logic         rst, key_load, decrypt, sk_ready;
    logic [0:191] keys;
    logic         sk_valid, sk_last, busy, done, parity_err;
    logic [0:47]  subkey;
    logic [5:0]   sk_idx;

    des_key_scheduler dut (
        .clk(clk), .rst(rst), .key_load(key_load), .keys(keys), .decrypt(decrypt),
        .sk_ready(sk_ready), .sk_valid(sk_valid), .subkey(subkey), .sk_idx(sk_idx),
        .sk_last(sk_last), .busy(busy), .done(done), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam logic [63:0] KT = 64'h133457799BBCDFF1;

    int checks = 0;
    int passes = 0;

    logic [47:0] obs_sk [48];
    int          obs_idx [48];
    int          hs_cyc [48];
    int          n_hs, first_valid, last_cyc, done_cyc, done_cnt, busy_bad, unstable, idle_bad;

    // Round n subkey (1..16) from the textbook schedule: C/D rotated by the cumulative shift total.
    function automatic logic [47:0] ref_sk(input logic [63:0] k, input int n);
        logic [1:64] kb;
        logic [1:28] c0, d0, c, d;
        logic [1:56] cd;
        logic [1:48] o;
        int t;
        kb = k;
        t = 0;
        for (int i = 0; i < n; i++) t += SHIFT[i];
        for (int i = 1; i <= 28; i++) begin
            c0[i] = kb[PC1[i-1]];
            d0[i] = kb[PC1[i+27]];
        end
        for (int i = 1; i <= 28; i++) begin
            c[i] = c0[((i - 1 + t) % 28) + 1];
            d[i] = d0[((i - 1 + t) % 28) + 1];
        end
        cd = {c, d};
        for (int j = 1; j <= 48; j++) o[j] = cd[PC2[j-1]];
        return o;
    endfunction

    function automatic logic [47:0] ref_stream(input logic [0:191] kb, input logic d, input int i);
        int s, r, ki;
        logic dord;
        logic [63:0] k;
        s = i / 16;
        r = i % 16;
        dord = d ^ (s == 1);
        ki = d ? 2 - s : s;
        k = kb[64*ki +: 64];
        return ref_sk(k, dord ? 16 - r : r + 1);
    endfunction

    function automatic logic ref_par(input logic [0:191] kb);
        for (int b = 0; b < 24; b++) if ($countones(kb[8*b +: 8]) % 2 == 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [0:191] rand192();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Loads a key bundle and records every handshake; mode 0: ready=1, 1: 3-cycle stall at idx 5, 2: random ready.
    task automatic run(input logic [0:191] k, input logic d, input int mode);
        logic pv, pr;
        logic [47:0] psk;
        logic [5:0] pidx;
        int stall;
        n_hs = 0; first_valid = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0;
        busy_bad = 0; unstable = 0; idle_bad = 0; stall = 0;
        pv = 1'b0; pr = 1'b1; psk = '0; pidx = '0;
        for (int i = 0; i < 48; i++) begin
            obs_sk[i] = 'x;
            obs_idx[i] = -1;
            hs_cyc[i] = -1;
        end
        @(negedge clk);
        keys = k; decrypt = d; key_load = 1'b1; sk_ready = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            key_load = 1'b0;
            keys = rand192();
            decrypt = 1'($urandom_range(0, 1));
            if (busy !== sk_valid) busy_bad++;
            if (pv && !pr && (subkey !== psk || sk_idx !== pidx)) unstable++;
            if (!sk_valid && (subkey !== 48'd0 || sk_idx !== 6'd0)) idle_bad++;
            if (sk_valid && first_valid < 0) first_valid = c;
            if (sk_last) last_cyc = c;
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (mode == 0) sk_ready = 1'b1;
            else if (mode == 1) begin
                sk_ready = !(sk_valid && sk_idx == 6'd5 && stall < 3);
                if (!sk_ready) stall++;
            end else sk_ready = $urandom_range(0, 3) != 0;
            if (sk_valid && sk_ready) begin
                if (n_hs < 48) begin
                    obs_sk[n_hs] = subkey;
                    obs_idx[n_hs] = int'(sk_idx);
                    hs_cyc[n_hs] = c;
                end
                n_hs++;
            end
            pv = sk_valid; pr = sk_ready; psk = subkey; pidx = sk_idx;
            if (done_cyc > 0 && c >= done_cyc + 2) break;
        end
        sk_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; key_load = 1'b1; keys = rand192(); decrypt = 1'b0; sk_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({sk_valid, busy, done, sk_last} !== 4'b0) $display("FAIL reset_ctrl: got %b want 0000", {sk_valid, busy, done, sk_last}); else passes++;
        checks++; if (subkey !== 48'd0) $display("FAIL reset_subkey: got %h want 0", subkey); else passes++;
        checks++; if (sk_idx !== 6'd0 || parity_err !== 1'b0) $display("FAIL reset_idx_par: got %0d/%b want 0/0", sk_idx, parity_err); else passes++;
        rst = 1'b0; key_load = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (sk_valid !== 1'b0) $display("FAIL reset_idle: got %b want 0", sk_valid); else passes++;
    endtask

    task automatic test_vector();
        logic [0:191] k;
        int bad, idxbad;
        k = {KT, KT, KT};
        run(k, 1'b0, 0);
        checks++; if (n_hs !== 48) $display("FAIL vec_count: got %0d want 48", n_hs); else passes++;
        checks++; if (obs_sk[0] !== 48'h1B02EFFC7072) $display("FAIL vec_idx0: got %h want 1b02effc7072", obs_sk[0]); else passes++;
        checks++; if (obs_sk[15] !== 48'hCB3D8B0E17F5) $display("FAIL vec_idx15: got %h want cb3d8b0e17f5", obs_sk[15]); else passes++;
        checks++; if (obs_sk[16] !== 48'hCB3D8B0E17F5) $display("FAIL vec_idx16: got %h want cb3d8b0e17f5", obs_sk[16]); else passes++;
        checks++; if (obs_sk[31] !== 48'h1B02EFFC7072) $display("FAIL vec_idx31: got %h want 1b02effc7072", obs_sk[31]); else passes++;
        checks++; if (obs_sk[32] !== 48'h1B02EFFC7072) $display("FAIL vec_idx32: got %h want 1b02effc7072", obs_sk[32]); else passes++;
        checks++; if (obs_sk[47] !== 48'hCB3D8B0E17F5) $display("FAIL vec_idx47: got %h want cb3d8b0e17f5", obs_sk[47]); else passes++;
        bad = 0; idxbad = 0;
        for (int i = 0; i < 48; i++) begin
            if (obs_sk[i] !== ref_stream(k, 1'b0, i)) bad++;
            if (obs_idx[i] != i || hs_cyc[i] != i + 1) idxbad++;
        end
        checks++; if (bad !== 0) $display("FAIL vec_model: got %0d bad subkeys want 0", bad); else passes++;
        checks++; if (idxbad !== 0) $display("FAIL vec_idx_timing: got %0d bad want 0", idxbad); else passes++;
        checks++; if (first_valid !== 1 || last_cyc !== 48) $display("FAIL vec_valid_window: got %0d..%0d want 1..48", first_valid, last_cyc); else passes++;
        checks++; if (done_cyc !== 49 || done_cnt !== 1) $display("FAIL vec_done: got cyc %0d cnt %0d want 49/1", done_cyc, done_cnt); else passes++;
        checks++; if (busy_bad !== 0 || idle_bad !== 0) $display("FAIL vec_busy_idle: got %0d/%0d want 0/0", busy_bad, idle_bad); else passes++;
        checks++; if (parity_err !== ref_par(k)) $display("FAIL vec_parity: got %b want %b", parity_err, ref_par(k)); else passes++;
    endtask

    task automatic test_stall();
        logic [0:191] k;
        int bad;
        k = rand192();
        run(k, 1'b0, 1);
        bad = 0;
        for (int i = 0; i < 48; i++) if (obs_sk[i] !== ref_stream(k, 1'b0, i) || obs_idx[i] != i) bad++;
        checks++; if (bad !== 0 || n_hs !== 48) $display("FAIL stall_model: got %0d bad, %0d hs want 0/48", bad, n_hs); else passes++;
        checks++; if (unstable !== 0) $display("FAIL stall_stable: got %0d changes want 0", unstable); else passes++;
        checks++; if (hs_cyc[5] !== 9) $display("FAIL stall_hs5: got cycle %0d want 9", hs_cyc[5]); else passes++;
        checks++; if (done_cyc !== 52) $display("FAIL stall_done: got cycle %0d want 52", done_cyc); else passes++;
    endtask

    task automatic test_decrypt();
        logic [0:191] k;
        int bad;
        k = {KT, 64'd0, 64'd0};
        run(k, 1'b1, 0);
        checks++; if (obs_sk[32] !== 48'hCB3D8B0E17F5) $display("FAIL dec_idx32: got %h want cb3d8b0e17f5", obs_sk[32]); else passes++;
        checks++; if (obs_sk[47] !== 48'h1B02EFFC7072) $display("FAIL dec_idx47: got %h want 1b02effc7072", obs_sk[47]); else passes++;
        bad = 0;
        for (int i = 0; i < 48; i++) if (obs_sk[i] !== ref_stream(k, 1'b1, i)) bad++;
        checks++; if (bad !== 0) $display("FAIL dec_model: got %0d bad want 0", bad); else passes++;
    endtask

    task automatic test_random();
        logic [0:191] k;
        logic d;
        int bad;
        for (int t = 0; t < 4; t++) begin
            k = rand192();
            d = 1'(t & 1);
            run(k, d, 2);
            bad = 0;
            for (int i = 0; i < 48; i++) if (obs_sk[i] !== ref_stream(k, d, i) || obs_idx[i] != i) bad++;
            checks++; if (bad !== 0 || n_hs !== 48 || done_cyc < 0) $display("FAIL rand_model[%0d]: got %0d bad, %0d hs, done %0d want 0/48/>0", t, bad, n_hs, done_cyc); else passes++;
            checks++; if (unstable !== 0 || done_cnt !== 1) $display("FAIL rand_stable[%0d]: got %0d/%0d want 0/1", t, unstable, done_cnt); else passes++;
            checks++; if (parity_err !== ref_par(k)) $display("FAIL rand_parity[%0d]: got %b want %b", t, parity_err, ref_par(k)); else passes++;
        end
    endtask

    task automatic test_abort();
        logic [0:191] ka, kb;
        int e, bad;
        ka = rand192();
        kb = rand192();
        e = 0; bad = 0;
        @(negedge clk);
        keys = ka; decrypt = 1'b0; key_load = 1'b1; sk_ready = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            keys = rand192();
            decrypt = 1'b1;
            key_load = sk_valid && sk_idx == 6'd10;
            if (sk_valid) begin
                if (int'(sk_idx) != e || subkey !== ref_stream(ka, 1'b0, e)) bad++;
                e++;
                if (sk_idx == 6'd20) begin
                    rst = 1'b1;
                    break;
                end
            end
        end
        key_load = 1'b0;
        checks++; if (bad !== 0 || e !== 21) $display("FAIL abort_ignore_load: got %0d bad, reached %0d want 0/21", bad, e); else passes++;
        @(negedge clk);
        checks++; if ({sk_valid, busy, done, sk_last} !== 4'b0 || subkey !== 48'd0 || sk_idx !== 6'd0) $display("FAIL abort_rst: got %b %h %0d want 0000 0 0", {sk_valid, busy, done, sk_last}, subkey, sk_idx); else passes++;
        rst = 1'b0;
        run(kb, 1'b1, 0);
        bad = 0;
        for (int i = 0; i < 48; i++) if (obs_sk[i] !== ref_stream(kb, 1'b1, i)) bad++;
        checks++; if (obs_idx[0] !== 0 || first_valid !== 1 || bad !== 0) $display("FAIL abort_restart: got idx0 %0d first %0d bad %0d want 0/1/0", obs_idx[0], first_valid, bad); else passes++;
    endtask

    task automatic test_parity();
        logic [0:191] k;
        int bad;
        k = {24{8'h01}};
        run(k, 1'b0, 0);
        checks++; if (parity_err !== 1'b0 || n_hs !== 48) $display("FAIL par_good: got %b/%0d want 0/48", parity_err, n_hs); else passes++;
        k[0:7] = 8'h00;
        run(k, 1'b0, 0);
        bad = 0;
        for (int i = 0; i < 48; i++) if (obs_sk[i] !== ref_stream(k, 1'b0, i)) bad++;
        checks++; if (parity_err !== 1'b1 || n_hs !== 48 || bad !== 0) $display("FAIL par_bad: got %b/%0d/%0d want 1/48/0", parity_err, n_hs, bad); else passes++;
    endtask

    initial begin
        test_reset();
        test_vector();
        test_stall();
        test_decrypt();
        test_random();
        test_abort();
        test_parity();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
